// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared constants for the hazard scoreboard: default latency
//               depth, stage/counter width, commit age, forwarding-select
//               encoding and the standard result latencies of each op class.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Deepest result latency, which is also the deepest bypassable stage.
  localparam int DEF_MAX_LAT    = 8;
  // Stage/counter field width, clog2(DEF_MAX_LAT+1).
  localparam int DEF_SW         = 4;
  // Writers this old are past the flush point and are kept on a flush.
  localparam int DEF_COMMIT_AGE = 3;

  // A fwd_sel of zero means "read the register file"; k means stage k.
  localparam int FWD_RF         = 0;

  // Result latencies of the common op classes.
  localparam int LAT_ALU        = 1;
  localparam int LAT_LOAD       = 2;
  localparam int LAT_MUL        = 4;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module      : sb_entry
// Description : Scoreboard state for one architectural register: busy flag,
//               cycles until the result is forwardable (cnt) and the stage
//               currently holding the result (age).
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               hold         - freeze aging
//               flush        - clear the entry if it is not yet committed
//               issue_i      - a new writer of this register issues now
//               lat_i        - legalised latency of that writer
//               retire_i     - register file write of this register
//               busy_o/cnt_o/age_o - current entry state
// Revision    : 1.0 - initial release
// ============================================================================
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int SW         = DEF_SW,
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int COMMIT_AGE = DEF_COMMIT_AGE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          issue_i,
  input  logic [SW-1:0] lat_i,
  input  logic          retire_i,
  output logic          busy_o,
  output logic [SW-1:0] cnt_o,
  output logic [SW-1:0] age_o
);

  localparam logic [SW-1:0] c_max_age    = SW'(MAX_LAT);
  localparam logic [SW-1:0] c_commit_age = SW'(COMMIT_AGE);
  localparam logic [SW-1:0] c_one        = SW'(1);

  logic          busy_q, busy_d;
  logic [SW-1:0] cnt_q,  cnt_d;
  logic [SW-1:0] age_q,  age_d;

  // Priority: a new writer beats a same-cycle retire of the old one; retire
  // and flush both simply free the entry; survivors age only when not held.
  // The top only raises issue_i when neither hold nor flush is active.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    age_d  = age_q;
    if (issue_i) begin
      busy_d = 1'b1;
      cnt_d  = lat_i - c_one;
      age_d  = c_one;
    end else if (retire_i || (flush && (age_q < c_commit_age))) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      age_d  = '0;
    end else if (busy_q && !hold) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - c_one;
      end
      if (age_q < c_max_age) begin
        age_d = age_q + c_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      age_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;
  assign age_o  = age_q;

endmodule : sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Register scoreboard between ID and the stall controller.
//               Tracks every in-flight writer, reports per source operand
//               whether to stall or which pipeline stage to bypass from, and
//               detects WAW hazards against slower in-flight writers.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               hold, flush         - pipeline freeze, kill uncommitted writers
//               id_valid            - ID holds an instruction trying to issue
//               id_src_addr/used    - NSRC source operands
//               id_dst_wen/addr     - destination register
//               id_lat              - result latency (1..MAX_LAT)
//               wb_wen, wb_addr     - register file write (retire)
//               stall               - issue must not proceed
//               fwd_sel             - per operand: 0 = regfile, k = stage k
//               busy_vec            - per-register pending-writer flag
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int NSRC       = 2,
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int SW         = DEF_SW,
  parameter int COMMIT_AGE = DEF_COMMIT_AGE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_src_addr,
  input  logic [NSRC-1:0]    id_src_used,
  input  logic               id_dst_wen,
  input  logic [AW-1:0]      id_dst_addr,
  input  logic [SW-1:0]      id_lat,
  input  logic               wb_wen,
  input  logic [AW-1:0]      wb_addr,
  output logic               stall,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic [NREG-1:0]    busy_vec
);

  localparam logic [SW-1:0] c_max_lat = SW'(MAX_LAT);
  localparam logic [SW-1:0] c_fwd_rf  = SW'(FWD_RF);

  logic [NREG-1:0] w_busy;
  logic [SW-1:0]   w_cnt [NREG];
  logic [SW-1:0]   w_age [NREG];
  logic [SW-1:0]   w_lat;
  logic            w_issue;
  logic            w_src_stall;
  logic            w_waw;

  // Out-of-range latencies are treated as the slowest legal one so that a
  // bad encoding can only over-stall, never forward a result too early.
  assign w_lat = ((id_lat == '0) || (id_lat > c_max_lat)) ? c_max_lat : id_lat;

  // Register 0 is hard-wired zero and never has a writer in flight.
  assign w_busy[0] = 1'b0;
  assign w_cnt[0]  = '0;
  assign w_age[0]  = '0;

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_entry
      sb_entry #(
        .SW         (SW),
        .MAX_LAT    (MAX_LAT),
        .COMMIT_AGE (COMMIT_AGE)
      ) u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .flush    (flush),
        .issue_i  (w_issue & id_dst_wen & (id_dst_addr == AW'(r))),
        .lat_i    (w_lat),
        .retire_i (wb_wen & (wb_addr == AW'(r))),
        .busy_o   (w_busy[r]),
        .cnt_o    (w_cnt[r]),
        .age_o    (w_age[r])
      );
    end
  endgenerate

  // Operand lookup: a pending writer with cnt > 0 has no forwardable result
  // yet; once cnt reaches 0 its age names the stage to bypass from.
  always_comb begin
    w_src_stall = 1'b0;
    fwd_sel     = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel[i*SW +: SW] = c_fwd_rf;
      if (id_src_used[i] && (id_src_addr[i*AW +: AW] != '0) &&
          w_busy[id_src_addr[i*AW +: AW]]) begin
        if (w_cnt[id_src_addr[i*AW +: AW]] != '0) begin
          w_src_stall = 1'b1;
        end else begin
          fwd_sel[i*SW +: SW] = w_age[id_src_addr[i*AW +: AW]];
        end
      end
    end
  end

  // WAW: the new writer must not finish before (or together with) the older
  // in-flight writer of the same register.
  assign w_waw = id_dst_wen && (id_dst_addr != '0) && w_busy[id_dst_addr] &&
                 (w_cnt[id_dst_addr] >= w_lat);

  assign stall    = id_valid & (w_src_stall | w_waw);
  assign w_issue  = id_valid & ~stall & ~hold & ~flush;
  assign busy_vec = w_busy;

`ifndef SYNTHESIS
  a_lat_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (id_valid && id_dst_wen) |-> ((id_lat != '0) && (id_lat <= c_max_lat)));
`endif

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed bench for hazard_scoreboard. Each vector drives one
//               cycle of ID/WB inputs and queues its hand-derived expected
//               stall/fwd_sel/busy_vec; a monitor on the falling edge pops
//               and compares.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic        id_dst_wen;
  logic [4:0]  id_dst_addr;
  logic [3:0]  id_lat;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic        stall;
  logic [7:0]  fwd_sel;
  logic [31:0] busy_vec;

  hazard_scoreboard u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src_addr (id_src_addr),
    .id_src_used (id_src_used),
    .id_dst_wen  (id_dst_wen),
    .id_dst_addr (id_dst_addr),
    .id_lat      (id_lat),
    .wb_wen      (wb_wen),
    .wb_addr     (wb_addr),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [7:0]  fwd;
    logic [31:0] busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] b(input int n);
    return 32'd1 << n;
  endfunction

  // One cycle of stimulus plus its expected response. With rst_mid set the
  // reset is pulled low mid-cycle, before the monitor samples.
  task automatic vec(input string nm, input logic v,
                     input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] used, input logic dw,
                     input logic [4:0] da, input logic [3:0] lat,
                     input logic h, input logic fl, input logic wb,
                     input logic [4:0] wa, input logic es,
                     input logic [3:0] ef0, input logic [3:0] ef1,
                     input logic [31:0] eb, input logic rst_mid = 1'b0);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_used = used;
    id_dst_wen  = dw;
    id_dst_addr = da;
    id_lat      = lat;
    hold        = h;
    flush       = fl;
    wb_wen      = wb;
    wb_addr     = wa;
    q.push_back('{name: nm, stall: es, fwd: {ef1, ef0}, busy: eb});
    if (rst_mid) begin
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      n_vec++;
      if (stall !== e.stall || fwd_sel !== e.fwd || busy_vec !== e.busy) begin
        n_fail++;
        $display("FAIL %s: got stall=%0b fwd_sel=%h busy_vec=%h, expected stall=%0b fwd_sel=%h busy_vec=%h",
                 e.name, stall, fwd_sel, busy_vec, e.stall, e.fwd, e.busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_src_addr = '0; id_src_used = '0; id_dst_wen = 1'b0; id_dst_addr = '0;
    id_lat = '0; wb_wen = 1'b0; wb_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //   name               v  s0  s1 us dw da lat h fl wb wa es f0 f1 busy
    vec("reset_state",      0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // asynchronous reset discards a pending writer
    vec("rst_issue_r4",     1,  0,  0, 0, 1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("rst_pending_r4",   1,  4,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, b(4));
    vec("rst_async",        1,  4,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    // ALU chain
    vec("alu_issue_r3",     1,  0,  0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("alu_fwd1",         0,  3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(3));
    vec("alu_fwd2",         1,  3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, b(3));
    // retire, same-cycle issue+retire, register 0
    vec("retire_r3_fwd3",   1,  3,  0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, b(3));
    vec("retired_r3",       1,  3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("issue_retire_r3",  1,  0,  0, 0, 1, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0);
    vec("issue_wins_age1",  0,  3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(3));
    vec("dst_r0_ret_r3",    1,  0,  0, 0, 1, 0, 1, 0, 0, 1, 3, 0, 0, 0, b(3));
    vec("r0_lookup",        1,  0,  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use
    vec("load_issue_r5",    1,  0,  0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("load_use_stall",   1,  0,  5, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, b(5));
    vec("load_use_fwd2",    1,  0,  5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, b(5));
    vec("retire_r5",        0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, b(5));
    // multi-cycle op and WAW
    vec("mul_issue_r7",     1,  0,  0, 0, 1, 7, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("waw_cnt3",         1,  0,  0, 0, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, b(7));
    vec("mul_src_cnt2",     1,  7,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, b(7));
    vec("waw_cnt1_eq_lat",  1,  0,  0, 0, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, b(7));
    vec("mul_fwd4_waw_ok",  1,  7,  0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 4, 0, b(7));
    vec("waw_new_age1",     0,  7,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(7));
    vec("retire_r7",        0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, b(7));
    // flush: writers at age 3, 2, 1
    vec("fl_issue_r10",     1,  0,  0, 0, 1,10, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("fl_issue_r11",     1,  0,  0, 0, 1,11, 8, 0, 0, 0, 0, 0, 0, 0, b(10));
    vec("fl_issue_r12",     1,  0,  0, 0, 1,12, 8, 0, 0, 0, 0, 0, 0, 0, b(10)|b(11));
    vec("flush",            1,  0,  0, 0, 1,13, 1, 0, 1, 0, 0, 0, 0, 0, b(10)|b(11)|b(12));
    // survivor r10 aged to cnt 4, so a lat-5 WAW is clear to issue
    vec("flush_survivor",   1,  0, 13, 2, 1,10, 5, 0, 0, 0, 0, 0, 0, 0, b(10));
    vec("retire_r10",       0,  0,  0, 0, 0, 0, 0, 0, 0, 1,10, 0, 0, 0, b(10));
    // hold freezes aging; retire still acts during hold
    vec("hold_issue_r9",    1,  0,  0, 0, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("hold1",            1,  9,  0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, b(9));
    vec("hold2",            1,  9,  0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, b(9));
    vec("hold_release",     1,  9,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, b(9));
    vec("hold_fwd2",        1,  9,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, b(9));
    vec("retire_in_hold",   0,  0,  0, 0, 0, 0, 0, 1, 0, 1, 9, 0, 0, 0, b(9));
    vec("final_idle",       0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked vectors, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_hazard_scoreboard
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised register scoreboard that detects data hazards and selects forwarding for the pipeline. It generalises the fixed 5-stage fwd_a/fwd_b/load-use logic to N source operands and variable per-instruction result latency, which covers multi-cycle ops such as mult/div. It sits between the ID stage and the controller's stall logic. It records each issued writer, ages it down the pipeline, and reports per operand whether to stall or which stage to bypass from.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero.
AW, 5, register address width, equal to clog2(NREG).
NSRC, 2, source operands checked per issue.
MAX_LAT, 8, maximum result latency in cycles, and the deepest bypassable stage.
SW, 4, stage/counter field width, equal to clog2(MAX_LAT+1).
COMMIT_AGE, 3, entries with age >= COMMIT_AGE survive a flush.

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous, active-low reset
hold  in  1  pipeline freeze (stall or debug step); state does not age
flush  in  1  kill uncommitted writers
id_valid  in  1  ID stage holds a valid instruction attempting issue
id_src_addr  in  NSRC*AW  source register addresses, operand i at [i*AW +: AW]
id_src_used  in  NSRC  operand i is read
id_dst_wen  in  1  instruction writes a register
id_dst_addr  in  AW  destination register
id_lat  in  SW  cycles until the result is forwardable; legal range 1..MAX_LAT
wb_wen  in  1  register file write this cycle (retire)
wb_addr  in  AW  register being written
stall  out  1  issue must not proceed this cycle
fwd_sel  out  NSRC*SW  per-operand source: 0 = register file, k = stage k result
busy_vec  out  NREG  per-register pending-writer flag (debug/verification)

Behaviour:
- Per-register entry: busy, cnt (SW bits, cycles until forwardable), age (SW bits, stage holding the result).
- Reset (rst_n low, asynchronous): all busy=0, cnt=0, age=0.
  - Outputs during reset: stall=0, fwd_sel=0, busy_vec=0.
  - A reset asserted mid-operation discards all pending entries immediately.
- Lookup is combinational from current state. For each operand i with id_src_used[i]=1 and a nonzero address:
  - Entry busy and cnt>0: operand is not ready.
  - Entry busy and cnt==0: fwd_sel[i]=age.
  - Otherwise: fwd_sel[i]=0.
- The stall condition is id_valid AND any of the following:
  - any used operand is not ready;
  - WAW: id_dst_wen, id_dst_addr!=0, destination entry busy, and its cnt >= id_lat.
- Issue condition: id_valid & !stall & !hold & !flush.
- On issue with id_dst_wen and a nonzero address, the next state of the destination entry is busy=1, cnt=id_lat-1, age=1.
- Aging happens on every clock with !hold. For each busy entry not being issued:
  - cnt decrements, saturating at 0;
  - age increments, saturating at MAX_LAT.
- Retire: wb_wen with a nonzero wb_addr clears that entry. This is independent of hold.
- Simultaneous issue and retire of the same register: the issue wins, so the new entry is recorded.
- Flush (!hold not required):
  - clears every entry with age < COMMIT_AGE;
  - suppresses issue that cycle;
  - flush has priority over aging. Entries that survive still age if !hold.
- Register 0 is never marked busy. Its lookup always yields fwd_sel=0 with no stall.
- Latency summary:
  - ALU (lat=1): the dependent op issues the next cycle with fwd_sel=1.
  - Load (lat=2): exactly one stall cycle, then fwd_sel=2.
- id_lat=0 or id_lat>MAX_LAT is illegal. It must be flagged by an assertion in simulation and is treated as MAX_LAT in RTL.

Decomposition:
- Shared header (define.vh): MAX_LAT, SW, the fwd_sel encoding constants (FWD_RF=0) and the latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4.
- Sub-module sb_entry: one register's busy/cnt/age flops plus issue, retire, flush and age logic. Instantiate it NREG-1 times with a generate loop.
- The top level holds the lookup muxes and the stall reduction.

Test Plan:
- Reset: issue dst r4 lat=3, then pull rst_n low mid-count -> busy_vec=0, stall=0 and fwd_sel=0 in the same cycle, asynchronously.
- ALU chain: issue r3 lat=1, next cycle src0=r3 -> stall=0, fwd_sel0=1; if held off one more (non-hold) cycle, fwd_sel0=2.
- Load-use: issue r5 lat=2, next src1=r5 -> stall=1 for exactly 1 cycle, then stall=0 with fwd_sel1=2.
- Multi-cycle and WAW: issue r7 lat=4, next cycle issue dst r7 lat=1 -> stall=1 until cnt=0; src=r7 stalls 3 cycles, then fwd_sel=4.
- Retire and r0: wb_wen r3 -> busy_vec[3]=0 and fwd_sel=0. Same-cycle issue plus retire of r3 -> busy_vec[3]=1 with age=1. Dst r0 -> never busy.
- Flush and hold: entries at age 1, 2, 3 plus flush -> only the age-3 entry survives (COMMIT_AGE=3). With hold=1 for 2 cycles, cnt and age stay unchanged.
